demuxer64_deser: RTL
====================

Name: demuxer64_deser

Overview:
Serial-to-parallel demultiplexer, the receive-side counterpart of the muxer8/muxer64 bit selectors. An internal index counter plays the role of sel and steers each accepted serial bit into position sel of a WIDTH-bit assembly register, LSB (sel=0) first. Completed words are handed off through a valid/ready output register. The block sits after a mux-based serializer and rebuilds its parallel word.

Parameters:
WIDTH, 64, word width in bits; legal values are powers of two, 2..64; the 8-bit variant uses WIDTH=8.
SEL_W, $clog2(WIDTH), index width; derived, never overridden.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst_n  input  1  synchronous active-low reset.
in_bit  input  1  serial data bit.
in_valid  input  1  in_bit is valid this cycle.
in_sync  input  1  qualified by in_valid; marks in_bit as bit 0 of a new word.
in_ready  output  1  block accepts in_bit this cycle.
sel  output  SEL_W  index the next accepted bit will occupy.
q  output  WIDTH  last completed word.
q_valid  output  1  q holds an unconsumed word.
q_ready  input  1  consumer takes q this cycle.
frame_err  output  1  one-cycle pulse: in_sync arrived with a partial word pending.

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a clk edge, with priority over everything else):
  - sel=0, assembly register acc=0, q=0, q_valid=0, frame_err=0.
  - Any partial word is discarded.
  - in_ready is 1 from the first cycle after reset.
- Accept = in_valid & in_ready. On an accept:
  - acc[sel] <= in_bit.
  - If sel==WIDTH-1, sel wraps to 0; otherwise sel <= sel+1.
- in_ready (combinational) = !(sel==WIDTH-1 && q_valid && !q_ready). It deasserts only when the last bit would overwrite an undrained word.
- Word complete: accept with sel==WIDTH-1.
  - Next cycle: q = {in_bit, acc[WIDTH-2:0]}, q_valid=1.
  - Latency: the last bit is visible on q one cycle after acceptance.
  - acc is cleared to 0 in the same edge.
- Output handshake:
  - q_valid && q_ready drops q_valid next cycle, unless a word completes in that same cycle; then q reloads and q_valid stays 1.
  - q holds its value while q_valid=1 and q_ready=0.
  - q keeps its last value after it is drained.
- Throughput: one bit per cycle sustained when q_ready=1. Back-to-back words need no bubble.
- in_sync handling (accept with in_sync=1):
  - in_bit is written to acc[0], the rest of acc is cleared, and sel <= 1.
  - If sel!=0 at that moment, frame_err pulses high for one cycle (the cycle after the accept) and the partial word is dropped. It is never emitted.
  - in_sync with sel==0 is legal and raises no error.
  - in_sync while in_ready=0 is ignored, because nothing is accepted.
- Inputs with in_valid=0 are ignored, including in_sync.
- The state machine follows sel/q_valid and needs no separate state register:
  - FILL: sel in 0..WIDTH-2.
  - LAST: sel==WIDTH-1, output free.
  - STALL: sel==WIDTH-1, q_valid=1, q_ready=0; in_ready=0.
  - STALL -> LAST when q_ready rises.
  - LAST -> FILL on accept.
- WIDTH=8 follows identical rules with SEL_W=3.

Test Plan:
1. Walking one, WIDTH=64, q_ready=1.
   - Stimulus: for k=0..63, send 64 bits where only bit index k is 1, first word with in_sync=1.
   - Required: each word gives q=64'h1<<k; q_valid pulses once per 64 accepts; sel reads 0 on each word boundary.
2. Walking zero.
   - Stimulus: send 64'hfffffffffffffffe serially, LSB first, then 64'hfffffffffffffffd, and so on (mirrors the muxer64 pattern).
   - Required: q matches each word exactly; no gap between words; frame_err stays 0.
3. Backpressure.
   - Stimulus: complete word A=64'h0123456789abcdef with q_ready=0, then stream 64 bits of B=64'hfedcba9876543210.
   - Required: in_ready=0 exactly when sel==63; q holds A.
   - Then raise q_ready for one cycle. Required: the bit is accepted that cycle and q=B next cycle.
4. Resync mid-word.
   - Stimulus: send 10 bits, then in_sync=1 with in_bit=1.
   - Required: frame_err=1 for exactly one cycle; sel=1; the partial word is never emitted; the next completed word has bit0=1.
5. Reset mid-operation.
   - Stimulus: assert rst_n=0 for one cycle at sel=37 with q_valid=1.
   - Required: next cycle sel=0, q_valid=0, q=0, in_ready=1. The following 64 bits form a clean word.
6. WIDTH=8 instance.
   - Stimulus: walking one (8'h01 through 8'h80), then 8'hfe, 8'hfd.
   - Required: q matches each byte; q_valid every 8 accepts; latency of 1 cycle.

Source files
------------

// File: rtl/demuxer64_deser_if.sv
// Serial-in / word-out handshake bundle for demuxer64_deser.
// The master drives bits and q_ready; the slave returns words.
interface demuxer64_deser_if #(
    parameter int WIDTH = 64
);
    localparam int SEL_W = $clog2(WIDTH);

    logic             in_bit;
    logic             in_valid;
    logic             in_sync;
    logic             in_ready;
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic             q_ready;
    logic             frame_err;

    modport master (
        output in_bit, in_valid, in_sync, q_ready,
        input  in_ready, sel, q, q_valid, frame_err
    );

    modport slave (
        input  in_bit, in_valid, in_sync, q_ready,
        output in_ready, sel, q, q_valid, frame_err
    );
endinterface

// File: rtl/demuxer64_deser.sv
// Serial-to-parallel demux: steers each accepted bit into acc[sel],
// LSB first, and hands completed words out through a valid/ready register.
module demuxer64_deser #(
    parameter int WIDTH = 64
) (
    input logic               clk,
    input logic               rst_n,
    demuxer64_deser_if.slave  bus
);
    localparam int SEL_W = $clog2(WIDTH);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(WIDTH - 1);

    localparam logic [1:0] ST_FILL  = 2'd0;
    localparam logic [1:0] ST_LAST  = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;

    logic [SEL_W-1:0] r_sel;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_q;
    logic             r_q_valid;
    logic             r_ferr;

    logic       w_last;
    logic [1:0] w_state;
    logic       w_ready;
    logic       w_accept;

    assign w_last = (r_sel == SEL_LAST);

    // State is implied by sel and the output register; no extra flops.
    always_comb begin
        w_state = ST_FILL;
        if (w_last) begin
            w_state = (r_q_valid && !bus.q_ready) ? ST_STALL : ST_LAST;
        end
    end

    assign w_ready  = (w_state != ST_STALL);
    assign w_accept = bus.in_valid && w_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sel     <= '0;
            r_acc     <= '0;
            r_q       <= '0;
            r_q_valid <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_ferr <= 1'b0;
            if (r_q_valid && bus.q_ready) begin
                r_q_valid <= 1'b0;
            end
            if (w_accept) begin
                if (bus.in_sync) begin
                    // Resync drops any partial word; it is never emitted.
                    r_acc  <= {{(WIDTH-1){1'b0}}, bus.in_bit};
                    r_sel  <= SEL_W'(1);
                    r_ferr <= (r_sel != '0);
                end else if (w_last) begin
                    r_q       <= {bus.in_bit, r_acc[WIDTH-2:0]};
                    r_q_valid <= 1'b1;
                    r_acc     <= '0;
                    r_sel     <= '0;
                end else begin
                    r_acc[r_sel] <= bus.in_bit;
                    r_sel        <= r_sel + SEL_W'(1);
                end
            end
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.sel       = r_sel;
    assign bus.q         = r_q;
    assign bus.q_valid   = r_q_valid;
    assign bus.frame_err = r_ferr;
endmodule
